// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and FSM states.
package hazard_pkg;

    // EX-stage operand source select
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } forward_t;

    // Multi-cycle condition tracker
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        DIV_BUSY = 2'b10
    } hz_state_t;

endpackage

// File: rtl/hazard_unit_forward_sel.sv
// Priority forwarding compare for one EX operand: MEM beats WB, x0 never forwarded.
module forward_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_m,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_w,
    input  logic                      i_we_m,
    input  logic                      i_we_w,
    output forward_t                  o_sel
);

    // MEM match first, then WB match, else register file
    always_comb begin
        o_sel = FWD_RF;
        if (i_we_m && (i_rd_m != '0) && (i_rd_m == i_rs)) begin
            o_sel = FWD_M;
        end else if (i_we_w && (i_rd_w != '0) && (i_rd_w == i_rs)) begin
            o_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load-use/branch stall-flush,
// and a small FSM for data-cache miss wait and the iterative divider.
// Build option: define HAZARD_DIV_EN to compile in the divider tracking logic.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned DIV_LATENCY    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      MemReadE,
    input  logic                      PCSrcE,
    input  logic                      DivStartE,
    input  logic                      DCacheMissM,
    input  logic                      DCacheReadyM,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushM,
    output logic                      FlushW,
    output logic                      DivDoneE
);

    forward_t  w_fwd_a;
    forward_t  w_fwd_b;
    hz_state_t r_state;
    logic      w_load_use;
    logic      w_branch;
    logic      w_fsm_stall_fde;
    logic      w_fsm_stall_m;
    logic      w_fsm_flush_w;
    logic      w_fsm_flush_m;
    logic      w_div_done;

`ifdef HAZARD_DIV_EN
    localparam int unsigned CNT_W = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
    logic [CNT_W-1:0] r_cnt;
    logic             r_div_done_q;
`else
    logic w_unused;
    assign w_unused = DivStartE | (DIV_LATENCY == 0);
`endif

    forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .i_rs   (Rs1E),
        .i_rd_m (RdM),
        .i_rd_w (RdW),
        .i_we_m (RegWriteM),
        .i_we_w (RegWriteW),
        .o_sel  (w_fwd_a)
    );

    forward_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .i_rs   (Rs2E),
        .i_rd_m (RdM),
        .i_rd_w (RdW),
        .i_we_m (RegWriteM),
        .i_we_w (RegWriteW),
        .o_sel  (w_fwd_b)
    );

    // Mealy stall/flush contributions of the multi-cycle FSM
    always_comb begin
        w_fsm_stall_fde = 1'b0;
        w_fsm_stall_m   = 1'b0;
        w_fsm_flush_w   = 1'b0;
        w_fsm_flush_m   = 1'b0;
        w_div_done      = 1'b0;
        case (r_state)
            RUN: begin
                if (DCacheMissM) begin
                    w_fsm_stall_fde = 1'b1;
                    w_fsm_stall_m   = 1'b1;
                    w_fsm_flush_w   = 1'b1;
                end
`ifdef HAZARD_DIV_EN
                else if (r_div_done_q) begin
                    w_div_done = 1'b1;
                end else if (DivStartE) begin
                    w_fsm_stall_fde = 1'b1;
                    w_fsm_flush_m   = 1'b1;
                end
`endif
            end
            MEM_WAIT: begin
                if (!DCacheReadyM) begin
                    w_fsm_stall_fde = 1'b1;
                    w_fsm_stall_m   = 1'b1;
                    w_fsm_flush_w   = 1'b1;
                end
            end
`ifdef HAZARD_DIV_EN
            DIV_BUSY: begin
                w_fsm_stall_fde = 1'b1;
                w_fsm_flush_m   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // FSM state, divide countdown and completion flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RUN;
`ifdef HAZARD_DIV_EN
            r_cnt        <= '0;
            r_div_done_q <= 1'b0;
`endif
        end else begin
            case (r_state)
                RUN: begin
                    if (DCacheMissM) begin
                        r_state <= MEM_WAIT;
                    end
`ifdef HAZARD_DIV_EN
                    else if (r_div_done_q) begin
                        r_div_done_q <= 1'b0;
                    end else if (DivStartE) begin
                        // a two-cycle divide has no busy cycles beyond the entry cycle
                        if (DIV_LATENCY <= 2) begin
                            r_div_done_q <= 1'b1;
                        end else begin
                            r_state <= DIV_BUSY;
                            r_cnt   <= CNT_W'(DIV_LATENCY - 2);
                        end
                    end
`endif
                end
                MEM_WAIT: begin
                    if (DCacheReadyM) begin
                        r_state <= RUN;
                    end
                end
`ifdef HAZARD_DIV_EN
                DIV_BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    // leave as the count reaches zero so DivDoneE lands at DIV_LATENCY-1
                    if (r_cnt == CNT_W'(1)) begin
                        r_state      <= RUN;
                        r_div_done_q <= 1'b1;
                    end
                end
`endif
                default: r_state <= RUN;
            endcase
        end
    end

    // Zero-latency load-use and branch detection
    always_comb begin
        w_load_use = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
        w_branch   = PCSrcE && !w_fsm_stall_fde;
    end

    // OR-combine contributions; every output forced low while in reset
    always_comb begin
        ForwardAE = rst ? FWD_RF : w_fwd_a;
        ForwardBE = rst ? FWD_RF : w_fwd_b;
        StallF    = !rst && (w_load_use || w_fsm_stall_fde);
        StallD    = !rst && (w_load_use || w_fsm_stall_fde);
        StallE    = !rst && w_fsm_stall_fde;
        StallM    = !rst && w_fsm_stall_m;
        FlushD    = !rst && w_branch;
        FlushE    = !rst && (w_load_use || w_branch);
        FlushM    = !rst && w_fsm_flush_m;
        FlushW    = !rst && w_fsm_flush_w;
        DivDoneE  = !rst && w_div_done;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (DIV_LATENCY=4); divide expectations follow HAZARD_DIV_EN.
module tb_hazard_unit;

    localparam int unsigned RW  = 5;
    localparam int unsigned LAT = 4;
`ifdef HAZARD_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif
    localparam logic D = DIV_EN;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RW-1:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic          RegWriteM = 0, RegWriteW = 0, MemReadE = 0, PCSrcE = 0;
    logic          DivStartE = 0, DCacheMissM = 0, DCacheReadyM = 0;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, DivDoneE;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_unit #(.REG_ADDR_WIDTH(RW), .DIV_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE), .PCSrcE(PCSrcE),
        .DivStartE(DivStartE), .DCacheMissM(DCacheMissM), .DCacheReadyM(DCacheReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .DivDoneE(DivDoneE)
    );

    always #5 clk = ~clk;

    // {FA,FB,StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,DivDoneE}
    wire [12:0] w_act = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                         FlushD, FlushE, FlushM, FlushW, DivDoneE};

    function automatic logic [12:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                       input logic sf, input logic sd, input logic se, input logic sm,
                                       input logic fd, input logic fe, input logic fm, input logic fw,
                                       input logic dd);
        return {fa, fb, sf, sd, se, sm, fd, fe, fm, fw, dd};
    endfunction

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Operand source by rule: newest non-x0 producer wins
    function automatic logic [1:0] fwd_ref(input logic [RW-1:0] rs,
                                           input logic wm, input logic [RW-1:0] rdm,
                                           input logic ww, input logic [RW-1:0] rdw);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 0) begin
            if (ww && rdw == rs) sel = 2'b01;
            if (wm && rdm == rs) sel = 2'b10;
        end
        return sel;
    endfunction

    // Cycle-indexed model: a divide started at cycle s stalls through s+LAT-2 and reports done at s+LAT-1
    int         cyc       = 0;
    int         m_done_at = -1;
    logic       m_miss_wait = 1'b0;
    logic       h4, h3, dd, lu, se, br;
    logic [12:0] exp_v;

    always @(negedge clk) begin
        if (rst) begin
            m_miss_wait = 1'b0;
            m_done_at   = -1;
            exp_v       = '0;
        end else begin
            h4 = 1'b0; h3 = 1'b0; dd = 1'b0;
            if (m_miss_wait) begin
                if (!DCacheReadyM) h4 = 1'b1;
                else m_miss_wait = 1'b0;
            end else if (m_done_at >= 0 && cyc < m_done_at) begin
                h3 = 1'b1;
            end else if (DCacheMissM) begin
                h4 = 1'b1;
                m_miss_wait = 1'b1;
            end else if (m_done_at >= 0) begin
                dd = 1'b1;
                m_done_at = -1;
            end else if (DIV_EN && DivStartE) begin
                h3 = 1'b1;
                m_done_at = cyc + int'(LAT) - 1;
            end
            lu = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            se = h3 | h4;
            br = PCSrcE && !se;
            exp_v = mk(fwd_ref(Rs1E, RegWriteM, RdM, RegWriteW, RdW),
                       fwd_ref(Rs2E, RegWriteM, RdM, RegWriteW, RdW),
                       lu | se, lu | se, se, h4, br, br | lu, h3, h4, dd);
        end
        chk("model", w_act, exp_v);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; MemReadE = 0; PCSrcE = 0;
        DivStartE = 0; DCacheMissM = 0; DCacheReadyM = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // reset with hazards present on every input
        tick();
        MemReadE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1; DCacheMissM = 1; DivStartE = 1;
        RegWriteM = 1; RdM = 3; Rs1E = 3;
        #1 chk("reset_zero", w_act, '0);
        tick(); clear_in(); rst = 0;
        #1 chk("idle", w_act, '0);

        // forwarding
        tick(); RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        #1 chk("fwd_mem_prio", w_act, mk(2'b10, 2'b00, 0,0,0,0,0,0,0,0,0));
        tick(); RegWriteM = 0;
        #1 chk("fwd_wb", w_act, mk(2'b01, 2'b00, 0,0,0,0,0,0,0,0,0));
        tick(); Rs1E = 0; RdM = 0; RegWriteM = 1; RdW = 0;
        #1 chk("fwd_x0", w_act, mk(2'b00, 2'b00, 0,0,0,0,0,0,0,0,0));
        tick(); RdM = 4; Rs1E = 4; RdW = 9; Rs2E = 9;
        #1 chk("fwd_a_m_b_w", w_act, mk(2'b10, 2'b01, 0,0,0,0,0,0,0,0,0));
        tick(); clear_in();

        // load-use
        tick(); MemReadE = 1; RdE = 7; Rs2D = 7;
        #1 chk("load_use", w_act, mk(0, 0, 1,1,0,0,0,1,0,0,0));
        tick(); MemReadE = 0;
        #1 chk("load_use_once", w_act, '0);
        tick(); MemReadE = 1; RdE = 0; Rs2D = 0;
        #1 chk("load_use_x0", w_act, '0);

        // branch
        tick(); clear_in(); PCSrcE = 1;
        #1 chk("branch", w_act, mk(0, 0, 0,0,0,0,1,1,0,0,0));

        // cache miss with a branch waiting in EX
        tick(); DCacheMissM = 1;
        #1 chk("miss_c0", w_act, mk(0, 0, 1,1,1,1,0,0,0,1,0));
        tick(); DCacheMissM = 0;
        #1 chk("miss_c1", w_act, mk(0, 0, 1,1,1,1,0,0,0,1,0));
        tick();
        #1 chk("miss_c2", w_act, mk(0, 0, 1,1,1,1,0,0,0,1,0));
        tick(); DCacheReadyM = 1;
        #1 chk("miss_c3_ready", w_act, mk(0, 0, 0,0,0,0,1,1,0,0,0));
        tick(); clear_in();
        #1 chk("miss_done", w_act, '0);

        // divide, DivStartE held through the done cycle
        tick(); DivStartE = 1;
        #1 chk("div_c0", w_act, mk(0, 0, D,D,D,0,0,0,D,0,0));
        tick();
        #1 chk("div_c1", w_act, mk(0, 0, D,D,D,0,0,0,D,0,0));
        tick();
        #1 chk("div_c2", w_act, mk(0, 0, D,D,D,0,0,0,D,0,0));
        tick();
        #1 chk("div_c3_done", w_act, mk(0, 0, 0,0,0,0,0,0,0,0,D));
        tick(); DivStartE = 0;
        #1 chk("div_c4_idle", w_act, '0);

        // simultaneous miss and divide start: miss first, divide after
        tick(); DCacheMissM = 1; DivStartE = 1;
        #1 chk("miss_div_c0", w_act, mk(0, 0, 1,1,1,1,0,0,0,1,0));
        tick(); DCacheMissM = 0;
        tick(); DCacheReadyM = 1;
        #1 chk("miss_div_ready", w_act, '0);
        tick(); DCacheReadyM = 0;
        #1 chk("div_after_miss", w_act, mk(0, 0, D,D,D,0,0,0,D,0,0));
        tick(); tick(); tick();
        #1 chk("div_after_miss_done", w_act, mk(0, 0, 0,0,0,0,0,0,0,0,D));
        tick(); DivStartE = 0;

        // reset in first busy cycle of a divide
        tick(); DivStartE = 1;
        #1 chk("rdiv_c0", w_act, mk(0, 0, D,D,D,0,0,0,D,0,0));
        tick(); DivStartE = 0; rst = 1; PCSrcE = 1;
        #1 chk("rdiv_in_reset", w_act, '0);
        tick(); rst = 0; PCSrcE = 0;
        #1 chk("rdiv_released", w_act, '0);
        repeat (5) tick();
        #1 chk("rdiv_no_done", w_act, '0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RISC-V core. Generates the 2-bit forwarding selects consumed by the EX-stage operand forwarding muxes. Also generates the per-stage stall and flush controls. Contains a small FSM for the two multi-cycle conditions: data-cache miss wait and the iterative divider.

## Interface
- REG_ADDR_WIDTH, 5: architectural register index width
- DIV_LATENCY, 32: total cycles a divide occupies EX; must be ≥ 2
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  REG_ADDR_WIDTH  source registers in ID
- Rs1E, Rs2E, RdE  in  REG_ADDR_WIDTH  source/destination registers in EX
- RdM, RdW  in  REG_ADDR_WIDTH  destination registers in MEM/WB
- RegWriteM, RegWriteW  in  1  destination write enable in MEM/WB
- MemReadE  in  1  EX instruction is a load
- PCSrcE  in  1  taken branch/jump resolved in EX
- DivStartE  in  1  EX instruction is a divide/remainder
- DCacheMissM  in  1  MEM load/store missed
- DCacheReadyM  in  1  miss data returned (handshake completion)
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushM, FlushW  out  1  load bubble into stage register
- DivDoneE  out  1  one-cycle pulse: divide result valid this cycle

## Operation
- Forwarding, per operand: MEM match (RegWriteM, RdM≠0, RdM==RsxE) → 10; else WB match → 01; else 00. MEM has priority over WB. x0 is never forwarded.
- Load-use: MemReadE && RdE≠0 && (RdE==Rs1D || RdE==Rs2D) → StallF, StallD, FlushE for that cycle only.
- Branch: PCSrcE → FlushD, FlushE, unless StallE is asserted. While StallE is asserted the flush is deferred; it fires on the cycle EX advances.
- FSM states: RUN, MEM_WAIT, DIV_BUSY.
  - RUN + DCacheMissM → MEM_WAIT. Stall outputs are asserted in the miss cycle (Mealy).
  - MEM_WAIT: StallF/D/E/M and FlushW stay asserted while !DCacheReadyM. The cycle DCacheReadyM is high: stalls and FlushW are deasserted and the FSM returns to RUN.
  - RUN + DivStartE + !div_done_q + !DCacheMissM → DIV_BUSY, cnt ← DIV_LATENCY−2. StallF/D/E and FlushM are asserted in the entry cycle.
  - DIV_BUSY: StallF/D/E and FlushM stay asserted; cnt decrements each cycle. At cnt==0 the FSM goes to RUN and sets div_done_q.
  - RUN with div_done_q: stalls are deasserted and DivDoneE is pulsed. DivStartE is masked for that one cycle so a completed divide cannot retrigger. div_done_q then clears.
- Simultaneous miss and divide start in RUN: the miss wins. The divide waits stalled in EX and starts once the FSM is back in RUN.
- DCacheMissM is ignored outside RUN.
- Stall/flush outputs combine by OR: load-use, branch, and FSM contributions are OR'd per output.

## Timing
- Forward*, load-use, and branch outputs are purely combinational; zero latency.
- Only the FSM state, cnt (clog2(DIV_LATENCY) bits), and div_done_q are registered.
- Divide: stalls cover DIV_LATENCY−1 cycles; DivDoneE fires in cycle DIV_LATENCY−1 relative to the start cycle 0.
- Reset: state=RUN, cnt=0, div_done_q=0. While rst is high, every output is 0.
- rst asserted mid-MEM_WAIT or mid-DIV_BUSY aborts immediately; no DivDoneE is produced.

## Configuration
- HAZARD_DIV_EN defined: the DIV_BUSY state, cnt, div_done_q, and DivDoneE logic are compiled in.
- HAZARD_DIV_EN undefined:
  - DivStartE is present but ignored.
  - DivDoneE is tied 0 and FlushM is driven only by rst-gated 0.
  - The FSM contains only RUN and MEM_WAIT.

## Structure
- Package hazard_pkg holds:
  - forward_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - hz_state_t enum: RUN, MEM_WAIT, DIV_BUSY
- Sub-module forward_sel: combinational priority compare for one operand, instantiated twice (A and B).

## Test plan
- Forwarding priority and x0 exclusion:
  - RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10.
  - Clear RegWriteM → ForwardAE=01.
  - Rs1E=RdM=0 with RegWriteM=1 → ForwardAE=00.
- Load-use: MemReadE=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for exactly one cycle. With RdE=0 → no stall.
- Branch: PCSrcE=1 with no stall → FlushD=FlushE=1, all stalls 0.
- Cache miss: DCacheMissM at cycle 0, DCacheReadyM at cycle 3 → StallF/D/E/M and FlushW high in cycles 0–2, low in cycle 3. PCSrcE held high throughout → FlushD/FlushE only in cycle 3.
- Divide with DIV_LATENCY=4 and HAZARD_DIV_EN defined:
  - DivStartE held high from cycle 0 → StallF/D/E and FlushM in cycles 0–2; DivDoneE=1 and no stall in cycle 3; no re-entry into DIV_BUSY.
  - Same stimulus with the macro undefined → no stalls at all.
- Reset mid-divide: rst pulsed in cycle 1 of DIV_BUSY → all outputs 0 during rst. After release the FSM is in RUN, and DivDoneE is never asserted for the aborted divide.
